// File: rtl/dma_mmio_engine_if.sv
// Request/ready bus bundle shared by the MMIO responder path and the DMA
// memory master path.
//   req   : access request, held by the master until ready
//   we    : 1 = write, 0 = read
//   addr  : byte address
//   wdata : write data
//   rdata : read data, valid while ready=1
//   ready : access-complete strobe from the slave
// master drives req/we/addr/wdata; slave drives rdata/ready.
interface dma_mmio_engine_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/dma_mmio_engine.sv
// DMA MMIO engine: register file (SRC/DST/LEN/CTRL/STAT/CLR/REMAIN) behind a
// fixed one-cycle MMIO responder, plus a word-granular memory-to-memory copy
// engine driving its own memory master port.
// Ports:
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   mmio    : slave side of the CPU register access bus
//   mem     : master side of the memory bus (to the RAM's second port)
//   dma_irq : level interrupt, done & irq_en
module dma_mmio_engine #(
  parameter int XLEN     = 32,
  parameter int OFS_BITS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  dma_mmio_engine_if.slave  mmio,
  dma_mmio_engine_if.master mem,
  output logic              dma_irq
);
  localparam int SEL_W = OFS_BITS - 2;

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t          state;
  logic [XLEN-1:0] src_q, dst_q, len_q;
  logic [XLEN-1:0] src_w, dst_w, remain, data_buf;
  logic            irq_en, busy, done, err;
  logic            mmio_ready_q;
  logic [XLEN-1:0] mmio_rdata_q;
  logic            mem_req_q, mem_we_q;
  logic [XLEN-1:0] mem_addr_q;

  logic            access;
  logic [SEL_W-1:0] sel;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] words;
  logic            unused_addr_bits;

  // The ready_q term blocks a second access from a request held through
  // the ready pulse.
  assign access = mmio.req & ~mmio_ready_q;
  assign sel    = mmio.addr[OFS_BITS-1:2];
  assign words  = len_q >> 2;
  assign unused_addr_bits = ^{mmio.addr[XLEN-1:OFS_BITS], mmio.addr[1:0]};

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_W'(0): rd_val = src_q;
      SEL_W'(1): rd_val = dst_q;
      SEL_W'(2): rd_val = len_q;
      SEL_W'(3): rd_val[1] = irq_en;
      SEL_W'(4): rd_val[2:0] = {err, done, busy};
      SEL_W'(6): rd_val = remain;
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      src_w        <= '0;
      dst_w        <= '0;
      remain       <= '0;
      data_buf     <= '0;
      irq_en       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mmio_ready_q <= 1'b0;
      mmio_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      // MMIO register access stage
      mmio_ready_q <= access;
      mmio_rdata_q <= access ? rd_val : '0;
      if (access && mmio.we) begin
        case (sel)
          SEL_W'(0): if (!busy) src_q <= mmio.wdata;
          SEL_W'(1): if (!busy) dst_q <= mmio.wdata;
          SEL_W'(2): if (!busy) len_q <= mmio.wdata;
          SEL_W'(3): begin
            irq_en <= mmio.wdata[1];
            if (mmio.wdata[0] && !busy) begin
              if ((src_q[1:0] | dst_q[1:0]) != 2'b00) begin
                err <= 1'b1;
              end else if (words == '0) begin
                done   <= 1'b1;
                remain <= '0;
              end else begin
                src_w      <= src_q;
                dst_w      <= dst_q;
                remain     <= words;
                busy       <= 1'b1;
                state      <= RD;
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b0;
                mem_addr_q <= src_q;
              end
            end
          end
          SEL_W'(5): begin
            if (mmio.wdata[1]) done <= 1'b0;
            if (mmio.wdata[2]) err  <= 1'b0;
          end
          default: ;
        endcase
      end

      // Copy engine stage; placed after the CLR decode so a hardware set
      // of done in FIN overrides a same-cycle clear.
      case (state)
        RD: if (mem.ready) begin
          data_buf   <= mem.rdata;
          mem_we_q   <= 1'b1;
          mem_addr_q <= dst_w;
          state      <= WR;
        end
        WR: if (mem.ready) begin
          src_w    <= src_w + XLEN'(4);
          dst_w    <= dst_w + XLEN'(4);
          remain   <= remain - XLEN'(1);
          mem_we_q <= 1'b0;
          if (remain == XLEN'(1)) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            state      <= FIN;
          end else begin
            mem_addr_q <= src_w + XLEN'(4);
            state      <= RD;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: ;
      endcase
    end
  end

  assign mmio.ready = mmio_ready_q;
  assign mmio.rdata = mmio_rdata_q;
  assign mem.req    = mem_req_q;
  assign mem.we     = mem_we_q;
  assign mem.addr   = mem_addr_q;
  assign mem.wdata  = mem_we_q ? data_buf : '0;
  assign dma_irq    = done & irq_en;

endmodule

// File: tb/tb_dma_mmio_engine.sv
// Directed bench for dma_mmio_engine: MMIO register access, copies with and
// without memory stalls, degenerate starts, busy protection and reset
// during a copy. A behavioural RAM answers the memory port; unwritten words
// read back as pat(addr).
module tb_dma_mmio_engine;
  logic clk = 1'b0;
  logic rst_n;
  logic dma_irq;

  dma_mmio_engine_if #(.XLEN(32)) mmio_bus ();
  dma_mmio_engine_if #(.XLEN(32)) mem_bus ();

  dma_mmio_engine #(.XLEN(32), .OFS_BITS(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mmio    (mmio_bus),
    .mem     (mem_bus),
    .dma_irq (dma_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic [31:0] ram    [0:1023];
  bit          wvalid [0:1023];
  acc_t        acc_log[$];
  int          stall      = 0;
  int          wait_cnt   = 0;
  int          req_cycles = 0;
  int          unstable   = 0;
  bit          pend       = 1'b0;
  logic [65:0] snap       = '0;
  int          n_chk      = 0;
  int          n_pass     = 0;
  int          lat_bad    = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return wvalid[a[11:2]] ? ram[a[11:2]] : pat(a);
  endfunction

  // Memory responder: grants at the falling edge after `stall` waiting
  // cycles; the access completes at the following rising edge.
  always @(negedge clk) begin
    if (pend && {mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata} != snap)
      unstable++;
    if (mem_bus.req) req_cycles++;
    if (rst_n && mem_bus.req && wait_cnt == stall) begin
      mem_bus.ready = 1'b1;
      mem_bus.rdata = mem_bus.we ? 32'h0 : rd_word(mem_bus.addr);
      acc_log.push_back({mem_bus.we, mem_bus.addr, mem_bus.wdata});
      if (mem_bus.we) begin
        ram[mem_bus.addr[11:2]]    = mem_bus.wdata;
        wvalid[mem_bus.addr[11:2]] = 1'b1;
      end
      wait_cnt = 0;
    end else begin
      mem_bus.ready = 1'b0;
      mem_bus.rdata = 32'h0;
      if (rst_n && mem_bus.req) wait_cnt++;
      else wait_cnt = 0;
    end
    pend = rst_n && mem_bus.req && !mem_bus.ready;
    snap = {mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic mmio_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    @(posedge clk); #1;
    mmio_bus.req   = 1'b1;
    mmio_bus.we    = w;
    mmio_bus.addr  = a;
    mmio_bus.wdata = d;
    @(posedge clk); #1;
    if (mmio_bus.ready !== 1'b1) lat_bad++;
    rd = mmio_bus.rdata;
    mmio_bus.req = 1'b0;
    mmio_bus.we  = 1'b0;
  endtask

  task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    mmio_acc(1'b1, a, d, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    mmio_acc(1'b0, a, 32'h0, v);
    check(tag, v, exp);
  endtask

  task automatic wait_done(input string tag, output int busy_polls, output int bad_polls);
    logic [31:0] s;
    bit seen;
    seen = 1'b0;
    busy_polls = 0;
    bad_polls = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      mmio_acc(1'b0, 32'h10, 32'h0, s);
      if (s[1]) seen = 1'b1;
      else begin
        busy_polls++;
        if (s != 32'h1) bad_polls++;
      end
    end
    check({tag, "_done"}, {31'b0, seen}, 32'h1);
  endtask

  task automatic check_copy(input string tag, input int base, input logic [31:0] src,
                            input logic [31:0] dst, input int n);
    acc_t e;
    check({tag, "_log_n"}, acc_log.size() - base, 2 * n);
    if (acc_log.size() >= base + 2 * n) begin
      for (int i = 0; i < n; i++) begin
        e = acc_log[base + 2 * i];
        check({tag, "_rd_we"}, {31'b0, e.we}, 32'h0);
        check({tag, "_rd_addr"}, e.addr, src + 32'(4 * i));
        e = acc_log[base + 2 * i + 1];
        check({tag, "_wr_we"}, {31'b0, e.we}, 32'h1);
        check({tag, "_wr_addr"}, e.addr, dst + 32'(4 * i));
        check({tag, "_wr_data"}, e.wdata, pat(src + 32'(4 * i)));
      end
    end
    for (int i = 0; i < n; i++)
      check({tag, "_ram"}, rd_word(dst + 32'(4 * i)), pat(src + 32'(4 * i)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, busy_polls, bad_polls, rc;
    bit found;
    mmio_bus.req   = 1'b0;
    mmio_bus.we    = 1'b0;
    mmio_bus.addr  = 32'h0;
    mmio_bus.wdata = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", {31'b0, mem_bus.req}, 32'h0);
    check("rst_mmio_ready", {31'b0, mmio_bus.ready}, 32'h0);
    check("rst_irq", {31'b0, dma_irq}, 32'h0);
    rst_n = 1'b1;
    rd_chk("rst_stat", 32'h10, 32'h0);
    rd_chk("rst_src", 32'h00, 32'h0);

    // Register read/write
    mmio_wr(32'h00, 32'h100);
    mmio_wr(32'h04, 32'h200);
    mmio_wr(32'h08, 32'h10);
    rd_chk("rw_src", 32'h00, 32'h100);
    rd_chk("rw_dst", 32'h04, 32'h200);
    rd_chk("rw_len", 32'h08, 32'h10);
    rd_chk("rw_stat", 32'h10, 32'h0);
    mmio_wr(32'h1C, 32'hFFFF_FFFF);
    rd_chk("rw_unused", 32'h1C, 32'h0);
    rd_chk("rw_clr_rd", 32'h14, 32'h0);

    // A held request yields one access, and rdata is 0 outside the pulse
    @(posedge clk); #1;
    mmio_bus.req = 1'b1; mmio_bus.we = 1'b0; mmio_bus.addr = 32'h04;
    @(posedge clk); #1;
    check("held_ready", {31'b0, mmio_bus.ready}, 32'h1);
    check("held_rdata", mmio_bus.rdata, 32'h200);
    @(posedge clk); #1;
    check("held_ready_low", {31'b0, mmio_bus.ready}, 32'h0);
    check("held_rdata_zero", mmio_bus.rdata, 32'h0);
    mmio_bus.req = 1'b0;

    // Four-word copy, no stalls, interrupt enabled
    base = acc_log.size();
    mmio_wr(32'h0C, 32'h3);
    wait_done("cp1", busy_polls, bad_polls);
    check_copy("cp1", base, 32'h100, 32'h200, 4);
    rd_chk("cp1_stat", 32'h10, 32'h2);
    rd_chk("cp1_remain", 32'h18, 32'h0);
    rd_chk("cp1_ctrl", 32'h0C, 32'h2);
    check("cp1_irq", {31'b0, dma_irq}, 32'h1);

    // Copy with three stall cycles per memory access
    mmio_wr(32'h14, 32'h6);
    rd_chk("st_clr_stat", 32'h10, 32'h0);
    check("st_irq_cleared", {31'b0, dma_irq}, 32'h0);
    stall = 3;
    mmio_wr(32'h00, 32'h140);
    mmio_wr(32'h04, 32'h300);
    base = acc_log.size();
    mmio_wr(32'h0C, 32'h3);
    wait_done("st", busy_polls, bad_polls);
    check("st_busy_seen", {31'b0, busy_polls >= 8}, 32'h1);
    check("st_stat_seq", bad_polls, 0);
    check("st_stable", unstable, 0);
    check_copy("st", base, 32'h140, 32'h300, 4);
    rd_chk("st_stat", 32'h10, 32'h2);
    stall = 0;

    // LEN below one word: done immediately, no memory traffic
    mmio_wr(32'h14, 32'h6);
    mmio_wr(32'h08, 32'h3);
    rc = req_cycles;
    mmio_wr(32'h0C, 32'h1);
    rd_chk("len3_stat", 32'h10, 32'h2);
    rd_chk("len3_remain", 32'h18, 32'h0);
    check("len3_no_req", req_cycles - rc, 0);
    mmio_wr(32'h14, 32'h6);
    rd_chk("clr_stat", 32'h10, 32'h0);

    // Misaligned source: error, no memory traffic
    mmio_wr(32'h00, 32'h102);
    mmio_wr(32'h08, 32'h10);
    rc = req_cycles;
    mmio_wr(32'h0C, 32'h1);
    rd_chk("err_stat", 32'h10, 32'h4);
    check("err_no_req", req_cycles - rc, 0);
    mmio_wr(32'h14, 32'h6);
    rd_chk("err_clr_stat", 32'h10, 32'h0);

    // Busy protection: SRC write and second start during a copy are ignored
    stall = 1;
    mmio_wr(32'h00, 32'h100);
    mmio_wr(32'h04, 32'h280);
    base = acc_log.size();
    mmio_wr(32'h0C, 32'h1);
    mmio_wr(32'h00, 32'hFFF0);
    mmio_wr(32'h0C, 32'h1);
    rd_chk("bp_src", 32'h00, 32'h100);
    wait_done("bp", busy_polls, bad_polls);
    repeat (20) @(posedge clk);
    check_copy("bp", base, 32'h100, 32'h280, 4);
    rd_chk("bp_stat", 32'h10, 32'h2);
    check("bp_irq_off", {31'b0, dma_irq}, 32'h0);

    // Reset while the engine is in a write access
    stall = 2;
    mmio_wr(32'h04, 32'h380);
    mmio_wr(32'h0C, 32'h3);
    check("rc_irq_before", {31'b0, dma_irq}, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_bus.req && mem_bus.we) found = 1'b1;
    end
    check("rc_reach_wr", {31'b0, found}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rc_mem_req", {31'b0, mem_bus.req}, 32'h0);
    check("rc_irq", {31'b0, dma_irq}, 32'h0);
    rst_n = 1'b1;
    rd_chk("rc_stat", 32'h10, 32'h0);
    rd_chk("rc_src", 32'h00, 32'h0);
    rd_chk("rc_remain", 32'h18, 32'h0);
    stall = 0;
    mmio_wr(32'h00, 32'h100);
    mmio_wr(32'h04, 32'h3C0);
    mmio_wr(32'h08, 32'h8);
    base = acc_log.size();
    mmio_wr(32'h0C, 32'h3);
    wait_done("rc2", busy_polls, bad_polls);
    check_copy("rc2", base, 32'h100, 32'h3C0, 2);
    rd_chk("rc2_stat", 32'h10, 32'h2);
    check("rc2_irq", {31'b0, dma_irq}, 32'h1);

    check("mmio_latency", lat_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dma_mmio_engine.md
Name: dma_mmio_engine

Overview:
- Responder end of the CPU DMA MMIO path. Takes the dma_mmio_* requests that the MMIO decoder routes on a DMA address hit.
- Holds the SRC/DST/LEN/CTRL/STAT/CLR register file.
- Runs a word-granular memory-to-memory copy through its own master port, wired to port B of dualport_bram.
- Raises a level interrupt on completion when enabled.

Parameters:
- XLEN, 32, data/address width (matches `XLEN).
- OFS_BITS, 5, low address bits used for register select (addr[4:2]); upper bits are already qualified by the decoder.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- dma_mmio_req  input  1  MMIO access request, held until ready
- dma_mmio_we  input  1  1 = write, 0 = read
- dma_mmio_addr  input  XLEN  byte address; addr[4:2] selects register
- dma_mmio_wdata  input  XLEN  write data
- dma_mmio_rdata  output  XLEN  read data, valid when ready=1
- dma_mmio_ready  output  1  one-cycle access-complete pulse
- dma_mem_req  output  1  memory request, held until dma_mem_ready
- dma_mem_we  output  1  memory write enable
- dma_mem_addr  output  XLEN  memory byte address
- dma_mem_wdata  output  XLEN  memory write data
- dma_mem_rdata  input  XLEN  memory read data, valid with ready
- dma_mem_ready  input  1  memory access complete
- dma_irq  output  1  level interrupt = STAT.done & CTRL.irq_en

Behaviour:
- Reset is synchronous and active-low; clk is the only clock. On rst_n=0 at a clk edge:
  - all registers, outputs and FSM state go to 0 / IDLE, including dma_mem_req=0 and dma_mmio_ready=0.
  - An in-flight copy is abandoned.
- Register map (offset):
  - 0x00 SRC, R/W.
  - 0x04 DST, R/W.
  - 0x08 LEN, R/W, bytes; copy count = LEN>>2, LEN[1:0] ignored.
  - 0x0C CTRL, R/W: bit0 start (write-1 trigger, reads 0), bit1 irq_en.
  - 0x10 STAT, RO: bit0 busy, bit1 done, bit2 err.
  - 0x14 CLR, WO: write bit1=1 clears done, write bit2=1 clears err; reads 0.
  - 0x18 REMAIN, RO: remaining words.
  - Offsets 0x1C and other unused offsets read 0; writes to them are ignored.
- MMIO handshake: fixed 1-cycle latency.
  - Cycle N: req=1 with ready_q=0 → cycle N+1: ready=1, rdata = register value sampled at N; a write commits at the N→N+1 edge.
  - ready is forced low in the cycle after a ready pulse, so a held req produces exactly one access.
  - rdata = 0 whenever ready=0.
- While busy, writes to SRC/DST/LEN are ignored; only irq_en and CLR take effect. A start written while busy is ignored.
- Start (CTRL.start=1 written while idle):
  - if SRC[1:0]|DST[1:0] != 0 → err=1, no transfer, FSM stays IDLE.
  - else if LEN>>2 == 0 → done=1 immediately, no memory access.
  - else load the working src/dst/remain and go to RD; busy=1.
- FSM IDLE → RD → WR → (RD | FIN) → IDLE:
  - RD: mem_req=1, we=0, addr=src_w. When dma_mem_ready=1, latch rdata into buf → WR.
  - WR: mem_req=1, we=1, addr=dst_w, wdata=buf. When ready=1: src_w+=4, dst_w+=4, remain−=1. Go to FIN if remain was 1, else RD. Address arithmetic wraps mod 2^XLEN.
  - FIN: busy=0, done=1 → IDLE (one cycle).
- mem_req, we, addr and wdata stay stable until ready is sampled. mem_req deasserts the cycle after the final ready. mem_wdata = 0 when we=0.
- Throughput: each word takes at least 2 cycles when memory ready is combinational in the request cycle.
- Simultaneous events: if hardware sets done (or err) in the same cycle that CLR clears it, set wins. A start in the same cycle as a CLR is processed; CLR applies first.
- dma_irq is combinational from registered done and irq_en.

Test Plan:
- Register R/W: write SRC=0x100, DST=0x200, LEN=0x10 → readback returns those values; each access sees ready exactly 1 cycle after req; STAT=0.
- Copy 4 words: preload RAM[0x100..0x10C]=A0..A3, irq_en=1, start → 4 RD/WR pairs at 0x100/0x200 … 0x10C/0x20C; RAM[0x200..0x20C]=A0..A3; STAT=0b010; dma_irq=1; REMAIN=0.
- Memory stalls: dma_mem_ready held low 3 cycles per access → req/addr/wdata remain stable; data is still correct; busy=1 for the whole copy.
- Edge cases:
  - LEN=3 then start → done=1 next cycle, no dma_mem_req.
  - SRC=0x102 then start → err=1 (STAT=0b100), no transfer.
  - CLR write 0b110 → STAT=0.
- Busy protection: during a copy, write SRC=0xFFF0 and a second start → SRC reads the original value, and only one transfer runs.
- Reset mid-copy: rst_n=0 while in WR → next edge mem_req=0, STAT=0, dma_irq=0; a new start after release behaves normally.
